// File: rtl/prg_dma_if.sv
// Host byte stream (hps_io ioctl) and DMA write port bundled for the PRG loader.
interface prg_dma_if #(
    parameter int ADDR_W = 16
);
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [7:0]        ioctl_dout;
    logic              ioctl_wait;
    logic              dma_ready;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [7:0]        dma_dout;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_dout, dma_ready,
        input  ioctl_wait, dma_we, dma_addr, dma_dout
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_dout, dma_ready,
        output ioctl_wait, dma_we, dma_addr, dma_dout
    );
endinterface

// File: rtl/prg_dma_loader.sv
// PRG loader: strips the 2-byte little-endian load address from the ioctl stream and
// writes the payload into machine RAM through a small FIFO and a stallable DMA port.
module prg_dma_loader #(
    parameter int                ADDR_W = 16,
    parameter logic [7:0]        INDEX  = 8'h41,
    parameter int                DEPTH  = 4,
    parameter logic [ADDR_W-1:0] LIMIT  = 16'h7FFF
) (
    input  logic              clk,
    input  logic              reset,
    prg_dma_if.slave          bus,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] load_start,
    output logic [ADDR_W-1:0] load_end,
    output logic              overflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_LO = 3'd1,
        S_HDR_HI = 3'd2,
        S_DATA   = 3'd3,
        S_FLUSH  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            state_r, state_nxt_s;
    logic              dl_prev_r;
    logic [7:0]        fifo_mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  count_r, count_nxt_s;
    logic [ADDR_W-1:0] ptr_r, load_start_r, load_end_r, last_addr_r;
    logic [7:0]        hdr_lo_r, last_dout_r;
    logic              overflow_r, wait_r, wait_nxt_s;
    logic              sel_s, accept_s, start_s, full_s, push_s, drop_s, pop_s, in_range_s, we_s;

    assign sel_s      = bus.ioctl_download & (bus.ioctl_index == INDEX);
    assign accept_s   = bus.ioctl_wr & sel_s &
                        ((state_r == S_HDR_LO) | (state_r == S_HDR_HI) | (state_r == S_DATA));
    assign start_s    = (state_r == S_IDLE) & sel_s & ~dl_prev_r;
    assign full_s     = (count_r == CNT_W'(DEPTH));
    assign push_s     = accept_s & (state_r == S_DATA) & ~full_s;
    assign drop_s     = accept_s & (state_r == S_DATA) & full_s;
    assign pop_s      = (count_r != {CNT_W{1'b0}}) & bus.dma_ready;
    // Bytes addressed above LIMIT still leave the FIFO so the pointer keeps advancing.
    assign in_range_s = (ptr_r <= LIMIT);
    assign we_s       = pop_s & in_range_s;

    // FIFO occupancy for the coming cycle.
    always_comb begin
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_W'(1'b1);
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - CNT_W'(1'b1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Load sequencing and host backpressure.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_s) state_nxt_s = S_HDR_LO;
                else         state_nxt_s = S_IDLE;
            end
            S_HDR_LO: begin
                if (!bus.ioctl_download) state_nxt_s = S_FLUSH;
                else if (accept_s)       state_nxt_s = S_HDR_HI;
                else                     state_nxt_s = S_HDR_LO;
            end
            S_HDR_HI: begin
                if (!bus.ioctl_download) state_nxt_s = S_FLUSH;
                else if (accept_s)       state_nxt_s = S_DATA;
                else                     state_nxt_s = S_HDR_HI;
            end
            S_DATA: begin
                if (!bus.ioctl_download) state_nxt_s = S_FLUSH;
                else                     state_nxt_s = S_DATA;
            end
            S_FLUSH: begin
                if (count_r == {CNT_W{1'b0}}) state_nxt_s = S_DONE;
                else                          state_nxt_s = S_FLUSH;
            end
            S_DONE:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase

        // One free slot is kept so a strobe already in flight from the host always fits.
        if ((state_nxt_s == S_FLUSH) || (state_nxt_s == S_DONE)) begin
            wait_nxt_s = 1'b1;
        end else if (state_nxt_s == S_IDLE) begin
            wait_nxt_s = 1'b0;
        end else begin
            wait_nxt_s = (count_nxt_s >= CNT_W'(DEPTH - 1));
        end
    end

    // FIFO storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_s) fifo_mem_r[wr_ptr_r] <= bus.ioctl_dout;
    end

    // Control state, pointers, header capture and load bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_IDLE;
            dl_prev_r    <= 1'b0;
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            ptr_r        <= {ADDR_W{1'b0}};
            load_start_r <= {ADDR_W{1'b0}};
            load_end_r   <= {ADDR_W{1'b0}};
            last_addr_r  <= {ADDR_W{1'b0}};
            hdr_lo_r     <= 8'h00;
            last_dout_r  <= 8'h00;
            overflow_r   <= 1'b0;
            wait_r       <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            dl_prev_r <= bus.ioctl_download;
            count_r   <= count_nxt_s;
            wait_r    <= wait_nxt_s;
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
                ptr_r    <= ptr_r + ADDR_W'(1'b1);
            end
            if (we_s) begin
                last_addr_r <= ptr_r;
                last_dout_r <= fifo_mem_r[rd_ptr_r];
                load_end_r  <= ptr_r + ADDR_W'(1'b1);
            end
            if (start_s) begin
                overflow_r   <= 1'b0;
                load_start_r <= {ADDR_W{1'b0}};
                load_end_r   <= {ADDR_W{1'b0}};
                wr_ptr_r     <= {PTR_W{1'b0}};
                rd_ptr_r     <= {PTR_W{1'b0}};
            end else if ((pop_s && !in_range_s) || drop_s) begin
                overflow_r <= 1'b1;
            end
            if (accept_s && (state_r == S_HDR_LO)) begin
                hdr_lo_r     <= bus.ioctl_dout;
                load_start_r <= ADDR_W'({8'h00, bus.ioctl_dout});
                load_end_r   <= ADDR_W'({8'h00, bus.ioctl_dout});
            end
            if (accept_s && (state_r == S_HDR_HI)) begin
                load_start_r <= ADDR_W'({bus.ioctl_dout, hdr_lo_r});
                load_end_r   <= ADDR_W'({bus.ioctl_dout, hdr_lo_r});
                ptr_r        <= ADDR_W'({bus.ioctl_dout, hdr_lo_r});
            end
        end
    end

    assign bus.ioctl_wait = wait_r;
    assign bus.dma_we     = we_s;
    assign bus.dma_addr   = we_s ? ptr_r : last_addr_r;
    assign bus.dma_dout   = we_s ? fifo_mem_r[rd_ptr_r] : last_dout_r;
    assign busy           = (state_r != S_IDLE);
    assign done           = (state_r == S_DONE);
    assign load_start     = load_start_r;
    assign load_end       = load_end_r;
    assign overflow       = overflow_r;
endmodule

// File: tb/tb_prg_dma_loader.sv
// Randomized bench for prg_dma_loader: two instances (LIMIT 7FFF and FFFF) share one
// host stream; a list-level reference model predicts each instance's writes.
module tb_prg_dma_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic dl = 1'b0, wr = 1'b0, rdy = 1'b0;
    logic [7:0] idx = 8'h00, dout = 8'h00;
    int   rmode = 0;

    logic busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
    logic [15:0] ls_a, le_a, ls_b, le_b;

    prg_dma_if #(.ADDR_W(16)) if_a ();
    prg_dma_if #(.ADDR_W(16)) if_b ();

    assign if_a.ioctl_download = dl;   assign if_b.ioctl_download = dl;
    assign if_a.ioctl_index    = idx;  assign if_b.ioctl_index    = idx;
    assign if_a.ioctl_wr       = wr;   assign if_b.ioctl_wr       = wr;
    assign if_a.ioctl_dout     = dout; assign if_b.ioctl_dout     = dout;
    assign if_a.dma_ready      = rdy;  assign if_b.dma_ready      = rdy;

    prg_dma_loader #(.ADDR_W(16), .INDEX(8'h41), .DEPTH(4), .LIMIT(16'h7FFF)) u_dut_a (
        .clk(clk), .reset(reset), .bus(if_a), .busy(busy_a), .done(done_a),
        .load_start(ls_a), .load_end(le_a), .overflow(ovf_a)
    );
    prg_dma_loader #(.ADDR_W(16), .INDEX(8'h41), .DEPTH(4), .LIMIT(16'hFFFF)) u_dut_b (
        .clk(clk), .reset(reset), .bus(if_b), .busy(busy_b), .done(done_b),
        .load_start(ls_b), .load_end(le_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [23:0] obs_a[$], obs_b[$], mq[$];
    logic [7:0]  stream[$];
    int dn_a = 0, dn_b = 0, wt_a = 0;
    int first_block, sent, last_wait_delta;
    logic [15:0] m_ls, m_le;
    logic        m_ovf;

    always @(negedge clk) begin
        if (if_a.dma_we) obs_a.push_back({if_a.dma_addr, if_a.dma_dout});
        if (if_b.dma_we) obs_b.push_back({if_b.dma_addr, if_b.dma_dout});
        if (done_a) dn_a++;
        if (done_b) dn_b++;
        if (if_a.ioctl_wait) wt_a++;
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0:       rdy = 1'b1;
                2:       rdy = 1'b0;
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: header bytes give the start, payload lands at consecutive (wrapping) addresses.
    task automatic model(input logic [15:0] limit);
        logic [15:0] p;
        mq.delete();
        m_ovf = 1'b0;
        m_ls  = 16'h0000;
        if (stream.size() >= 1) m_ls = {8'h00, stream[0]};
        if (stream.size() >= 2) m_ls = {stream[1], stream[0]};
        m_le = m_ls;
        p    = m_ls;
        for (int i = 2; i < stream.size(); i++) begin
            if (p <= limit) begin
                mq.push_back({p, stream[i]});
                m_le = p + 16'd1;
            end else begin
                m_ovf = 1'b1;
            end
            p = p + 16'd1;
        end
    endtask

    task automatic score(input string tag, input logic [15:0] limit, input logic [23:0] obs[$],
                         input int base, input int dn, input logic [15:0] ls, input logic [15:0] le,
                         input logic ovf, input bit match);
        model(limit);
        if (!match) mq.delete();
        check_val({tag, "_nwr"}, obs.size() - base, mq.size());
        for (int i = 0; i < mq.size() && base + i < obs.size(); i++)
            check_val($sformatf("%s_wr%0d", tag, i), obs[base + i], mq[i]);
        check_val({tag, "_done"}, dn, match ? 1 : 0);
        if (match) begin
            check_val({tag, "_start"}, ls, m_ls);
            check_val({tag, "_end"}, le, m_le);
            check_val({tag, "_ovf"}, ovf, m_ovf);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int g = 0;
        if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
        while (if_a.ioctl_wait && g < 300) begin
            if (rmode == 2 && first_block < 0) first_block = sent;
            @(posedge clk); #1;
            g++;
        end
        if (g >= 300) check_val("wait_bound", g, 299);
        wr = 1'b1; dout = b;
        @(posedge clk); #1;
        wr = 1'b0;
        sent++;
    endtask

    task automatic start_stream(input logic [7:0] index);
        first_block = -1; sent = 0;
        idx = index; dl = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_load(input string tag, input logic [7:0] index, input int stall);
        int ba, bb, da, db, wa;
        ba = obs_a.size(); bb = obs_b.size(); da = dn_a; db = dn_b; wa = wt_a;
        start_stream(index);
        fork
            begin
                if (stall > 0) begin
                    rmode = 2;
                    repeat (stall) @(posedge clk);
                    #1 rmode = 0;
                end
            end
            begin
                foreach (stream[i]) send_byte(stream[i]);
            end
        join
        dl = 1'b0;
        for (int c = 0; c < 300 && (busy_a || busy_b); c++) begin @(posedge clk); #1; end
        repeat (3) @(posedge clk);
        #1;
        check_val({tag, "_idle"}, {busy_a, busy_b}, 2'b00);
        score({tag, "_a"}, 16'h7FFF, obs_a, ba, dn_a - da, ls_a, le_a, ovf_a, index == 8'h41);
        score({tag, "_b"}, 16'hFFFF, obs_b, bb, dn_b - db, ls_b, le_b, ovf_b, index == 8'h41);
        last_wait_delta = wt_a - wa;
    endtask

    initial begin
        int ba, da;
        int n;
        logic [15:0] h;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", busy_a, 1'b0);
        check_val("rst_outs", {done_a, ovf_a, if_a.ioctl_wait, if_a.dma_we}, 4'h0);
        check_val("rst_ptrs", {ls_a, le_a, if_a.dma_addr}, 48'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        check_val("idle_outs", {busy_a, done_a, if_a.ioctl_wait, if_b.ioctl_wait}, 4'h0);

        rmode = 0;
        stream = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC};
        run_load("basic", 8'h41, 0);

        stream = '{8'h00, 8'h10};
        for (int i = 0; i < 10; i++) stream.push_back(8'($urandom));
        run_load("bp", 8'h41, 20);
        check_val("bp_block_at", first_block, 5);

        stream = '{8'hFE, 8'h7F, 8'h11, 8'h22, 8'h33, 8'h44};
        run_load("limit", 8'h41, 0);

        stream = '{8'hFF, 8'hFF, 8'h5A, 8'hA5};
        run_load("wrap", 8'h41, 0);

        stream = '{8'h00, 8'h20, 8'h01, 8'h02, 8'h03};
        run_load("foreign", 8'h01, 0);
        check_val("foreign_wait", last_wait_delta, 0);

        stream = '{8'h5A};
        run_load("short1", 8'h41, 0);
        stream.delete();
        run_load("short0", 8'h41, 0);

        // Abort a load with two payload bytes still queued behind a stalled target.
        ba = obs_a.size(); da = dn_a;
        rmode = 2;
        stream = '{8'h00, 8'h20, 8'h11, 8'h22};
        start_stream(8'h41);
        foreach (stream[i]) send_byte(stream[i]);
        #3 reset = 1'b1;
        dl = 1'b0;
        #1;
        check_val("abort_busy", busy_a, 1'b0);
        check_val("abort_outs", {if_a.dma_we, if_a.ioctl_wait, ovf_a}, 3'b000);
        check_val("abort_ptrs", {ls_a, le_a, if_a.dma_addr}, 48'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        rmode = 0;
        repeat (10) @(posedge clk);
        #1;
        check_val("abort_nwr", obs_a.size() - ba, 0);
        check_val("abort_done", dn_a - da, 0);
        stream = '{8'h00, 8'h30, 8'h5A, 8'hA5};
        run_load("after_abort", 8'h41, 0);

        rmode = 1;
        for (int t = 0; t < 10; t++) begin
            n = $urandom_range(0, 12);
            case ($urandom_range(0, 2))
                0:       h = 16'h7FF8 + 16'($urandom_range(0, 8));
                1:       h = 16'hFFF8 + 16'($urandom_range(0, 7));
                default: h = 16'($urandom);
            endcase
            stream.delete();
            if (n >= 1) stream.push_back(h[7:0]);
            if (n >= 2) stream.push_back(h[15:8]);
            for (int i = 2; i < n; i++) stream.push_back(8'($urandom));
            run_load($sformatf("rnd%0d", t), 8'h41, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
